// File: rtl/code_mask_decoder.sv
// Streaming 4-to-16 index decoder: ORs one-hot bits from a beat sequence into a
// mask and presents mask, popcount and duplicate flag on a registered valid/ready port.
module code_mask_decoder #(
  parameter int MASK_W = 16,
  parameter int CODE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_nz,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MASK_W-1:0] out_mask,
  output logic [4:0]        out_popcnt,
  output logic              out_dup,
  output logic              dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // Producers hold payload stable while valid=1 and ready=0.

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t            state;
  logic [MASK_W-1:0] acc;
  logic [4:0]        cnt;
  logic              dup;

  logic              accept;
  logic              hit;
  logic [MASK_W-1:0] onehot;
  logic [MASK_W-1:0] next_acc;
  logic [4:0]        next_cnt;
  logic              next_dup;

  // In HOLD the input is only taken when the pending mask drains in the same
  // cycle, so back-to-back single-beat groups stream at full rate.
  assign in_ready  = (state == ACCUM) || out_ready;
  assign out_valid = (state == HOLD);
  assign dbg_state = state;
  assign accept    = in_valid && in_ready;

  always_comb begin
    onehot = '0;
    if (in_nz) onehot = {{(MASK_W-1){1'b0}}, 1'b1} << in_code;
    hit      = in_nz && acc[in_code];
    next_acc = acc | onehot;
    next_cnt = cnt + {4'b0000, (in_nz && !hit)};
    next_dup = dup | hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      acc        <= '0;
      cnt        <= '0;
      dup        <= 1'b0;
      out_mask   <= '0;
      out_popcnt <= '0;
      out_dup    <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        out_mask   <= next_acc;
        out_popcnt <= next_cnt;
        out_dup    <= next_dup;
        acc        <= '0;
        cnt        <= '0;
        dup        <= 1'b0;
        state      <= HOLD;
      end else begin
        acc   <= next_acc;
        cnt   <= next_cnt;
        dup   <= next_dup;
        // A non-last beat taken in HOLD means the pending mask drained.
        state <= ACCUM;
      end
    end else if (state == HOLD && out_ready) begin
      state <= ACCUM;
    end
  end

endmodule

// File: tb/tb_code_mask_decoder.sv
// Bench for code_mask_decoder: directed groups with literal expectations plus
// randomized traffic checked every cycle against a group-level reference model.
module tb_code_mask_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_code;
  logic        in_nz;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_mask;
  logic [4:0]  out_popcnt;
  logic        out_dup;
  logic        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  code_mask_decoder #(.MASK_W(16), .CODE_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_nz(in_nz), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
    .out_popcnt(out_popcnt), .out_dup(out_dup), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A group is the list of nz codes seen so far; its result is the set of
  // distinct codes as a mask, the set size, and whether any code repeated.
  int          grp_codes[$];
  bit          m_valid = 1'b0;
  logic [15:0] m_mask  = '0;
  int          m_pop   = 0;
  bit          m_dup   = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        grp_codes.delete();
        m_valid = 1'b0;
        m_mask  = '0;
        m_pop   = 0;
        m_dup   = 1'b0;
      end else begin
        bit take;
        take = in_valid && (!m_valid || out_ready);
        if (m_valid && out_ready) m_valid = 1'b0;
        if (take) begin
          if (in_nz) grp_codes.push_back(int'(in_code));
          if (in_last) begin
            logic [15:0] s;
            s = '0;
            foreach (grp_codes[i]) s[grp_codes[i]] = 1'b1;
            m_mask  = s;
            m_pop   = $countones(s);
            m_dup   = (grp_codes.size() != m_pop);
            m_valid = 1'b1;
            grp_codes.delete();
          end
        end
      end
    end
  end

  // ---------------- scoreboard compare (every cycle, away from posedge) ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      check("model_dbg_state", {31'b0, dbg_state}, {31'b0, m_valid});
      check("model_in_ready", {31'b0, in_ready}, {31'b0, (!m_valid || out_ready)});
      if (m_valid) begin
        check("model_out_mask", {16'b0, out_mask}, {16'b0, m_mask});
        check("model_out_popcnt", {27'b0, out_popcnt}, m_pop);
        check("model_out_dup", {31'b0, out_dup}, {31'b0, m_dup});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_valid = 1'b0;
    in_code  = '0;
    in_nz    = 1'b0;
    in_last  = 1'b0;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [3:0] code, input logic nz, input logic last);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_code  = code;
    in_nz    = nz;
    in_last  = last;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("beat_accept_timeout", 32'd0, 32'd1);
    idle_inputs();
  endtask

  // Drain the pending output in one handshake cycle.
  task automatic pop_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [15:0] mask,
                            input int pop, input logic dup);
    check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({name, "_mask"}, {16'b0, out_mask}, {16'b0, mask});
    check({name, "_popcnt"}, {27'b0, out_popcnt}, pop);
    check({name, "_dup"}, {31'b0, out_dup}, {31'b0, dup});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_mask", {16'b0, out_mask}, 32'd0);
    check("reset_out_popcnt", {27'b0, out_popcnt}, 32'd0);
    check("reset_out_dup", {31'b0, out_dup}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Group 3, 7, 15: out_valid must be high right after the last edge.
    send_beat(4'd3, 1'b1, 1'b0);
    send_beat(4'd7, 1'b1, 1'b0);
    send_beat(4'd15, 1'b1, 1'b1);
    expect_out("grp_3_7_15", 16'h8088, 3, 1'b0);
    pop_out();

    // Duplicates plus an all-zero last beat.
    send_beat(4'd5, 1'b1, 1'b0);
    send_beat(4'd5, 1'b1, 1'b0);
    send_beat(4'd0, 1'b1, 1'b0);
    send_beat(4'd9, 1'b0, 1'b1);
    expect_out("grp_dup", 16'h0021, 2, 1'b1);
    pop_out();

    // 17-beat group saturating the mask.
    for (int i = 0; i < 16; i++) send_beat(4'(i), 1'b1, 1'b0);
    send_beat(4'd9, 1'b1, 1'b1);
    expect_out("grp_full", 16'hFFFF, 16, 1'b1);
    pop_out();

    // Back-to-back single-beat groups with out_ready held high.
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      logic [15:0] m;
      in_valid = 1'b1;
      in_code  = 4'(i);
      in_nz    = 1'b1;
      in_last  = 1'b1;
      @(negedge clk);
      check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      m = 16'h0001 << i;
      expect_out("b2b", m, 1, 1'b0);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Output held while out_ready=0 with a pending input beat.
    send_beat(4'd10, 1'b1, 1'b1);
    in_valid = 1'b1;
    in_code  = 4'd12;
    in_nz    = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      expect_out("stall_hold", 16'h0400, 1, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    idle_inputs();
    out_ready = 1'b0;
    expect_out("stall_next", 16'h1000, 1, 1'b0);
    pop_out();

    // Reset mid-group must leave no residue.
    send_beat(4'd4, 1'b1, 1'b0);
    send_beat(4'd6, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(4'd1, 1'b1, 1'b1);
    expect_out("after_rst", 16'h0002, 1, 1'b0);
    pop_out();

    // Randomized traffic; the scoreboard checks every cycle.
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_code   = 4'($urandom_range(0, 15));
      in_nz     = ($urandom_range(0, 7) != 0);
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    idle_inputs();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
